// File: rtl/game_round_scheduler_if.sv
// Round scheduler bus: control pulses in, round status and time-base ticks out.
interface game_round_scheduler_if;
  logic       start;
  logic       hit;
  logic [1:0] state;
  logic [7:0] time_left;
  logic [7:0] score;
  logic [2:0] level;
  logic       sec_tick;
  logic       mole_tick;
  logic       playing;
  logic       game_over;

  // Driver side (game controller / testbench).
  modport master (
    output start,
    output hit,
    input  state,
    input  time_left,
    input  score,
    input  level,
    input  sec_tick,
    input  mole_tick,
    input  playing,
    input  game_over
  );

  // Scheduler side.
  modport slave (
    input  start,
    input  hit,
    output state,
    output time_left,
    output score,
    output level,
    output sec_tick,
    output mole_tick,
    output playing,
    output game_over
  );
endinterface

// File: rtl/game_round_scheduler.sv
// Whack-a-mole round sequencer: IDLE -> COUNTDOWN -> PLAY -> GAMEOVER.
// Owns the one-second and mole-step time bases and tracks time, score and level.
module game_round_scheduler #(
  parameter int unsigned SEC_CYCLES       = 50000000,
  parameter int unsigned COUNTDOWN_SECS   = 3,
  parameter int unsigned GAME_SECS        = 30,
  parameter int unsigned HITS_PER_LEVEL   = 5,
  parameter int unsigned MAX_LEVEL        = 7,
  parameter int unsigned BASE_MOLE_CYCLES = 50000000,
  parameter int unsigned MOLE_STEP_CYCLES = 5000000
) (
  input logic                   clk,
  input logic                   rst,
  game_round_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StCountdown = 2'b01,
    StPlay      = 2'b10,
    StGameover  = 2'b11
  } state_e;

  localparam logic [31:0] SecLast       = 32'(SEC_CYCLES - 1);
  localparam logic [7:0]  CountdownSecs = 8'(COUNTDOWN_SECS);
  localparam logic [7:0]  GameSecs      = 8'(GAME_SECS);
  localparam logic [31:0] HitsPerLevel  = 32'(HITS_PER_LEVEL);
  localparam logic [2:0]  MaxLevel      = 3'(MAX_LEVEL);
  localparam logic [31:0] BaseMole      = 32'(BASE_MOLE_CYCLES);
  localparam logic [31:0] MoleStep      = 32'(MOLE_STEP_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] sec_cnt_q, sec_cnt_d;
  logic [31:0] mole_cnt_q, mole_cnt_d;
  logic [31:0] hits_q, hits_d;
  logic [7:0]  time_left_q, time_left_d;
  logic [7:0]  score_q, score_d;
  logic [2:0]  level_q, level_d;
  logic        sec_tick_q, sec_tick_d;
  logic        mole_tick_q, mole_tick_d;
  logic        playing_q, playing_d;
  logic        game_over_q, game_over_d;

  logic        timed;
  logic        sec_evt;
  logic        last_sec;
  logic        mole_evt;
  logic        hit_evt;
  logic        start_evt;
  logic [31:0] mole_period;

  // Event decode shared by the next-state and datapath logic.
  assign timed       = (state_q == StCountdown) || (state_q == StPlay);
  assign sec_evt     = timed && (sec_cnt_q == SecLast);
  assign last_sec    = sec_evt && (time_left_q == 8'd1);
  assign mole_period = BaseMole - (32'(level_q) * MoleStep);
  // >= rather than == so a level-up that shrinks the period below the current
  // count fires right away instead of waiting for a 32-bit wrap.
  assign mole_evt    = (state_q == StPlay) && (mole_cnt_q >= (mole_period - 32'd1));
  assign hit_evt     = (state_q == StPlay) && bus.hit;
  assign start_evt   = ((state_q == StIdle) || (state_q == StGameover)) && bus.start;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StGameover: begin
        if (bus.start) state_d = StCountdown;
      end
      StCountdown: begin
        if (last_sec) state_d = StPlay;
      end
      StPlay: begin
        if (last_sec) state_d = StGameover;
      end
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    sec_cnt_d   = 32'd0;
    mole_cnt_d  = 32'd0;
    hits_d      = hits_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    level_d     = level_q;
    sec_tick_d  = sec_evt;
    mole_tick_d = mole_evt;
    playing_d   = (state_d == StPlay);
    game_over_d = (state_d == StGameover);

    // Second counter runs only while timed and restarts on every state entry.
    if (timed && (state_d == state_q)) begin
      sec_cnt_d = sec_evt ? 32'd0 : sec_cnt_q + 32'd1;
    end

    // Mole counter is parked at zero outside PLAY.
    if ((state_q == StPlay) && (state_d == StPlay)) begin
      mole_cnt_d = mole_evt ? 32'd0 : mole_cnt_q + 32'd1;
    end

    if (start_evt) begin
      time_left_d = CountdownSecs;
      score_d     = 8'd0;
      level_d     = 3'd0;
      hits_d      = 32'd0;
    end else if (sec_evt) begin
      if (last_sec) begin
        time_left_d = (state_q == StCountdown) ? GameSecs : 8'd0;
      end else begin
        time_left_d = time_left_q - 8'd1;
      end
    end

    if (hit_evt) begin
      if (score_q != 8'hff) score_d = score_q + 8'd1;
      // Hits-in-level keeps cycling at the top level; only level saturates.
      if ((hits_q + 32'd1) >= HitsPerLevel) begin
        hits_d = 32'd0;
        if (level_q != MaxLevel) level_d = level_q + 3'd1;
      end else begin
        hits_d = hits_q + 32'd1;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt_q   <= 32'd0;
      mole_cnt_q  <= 32'd0;
      hits_q      <= 32'd0;
      time_left_q <= 8'd0;
      score_q     <= 8'd0;
      level_q     <= 3'd0;
      sec_tick_q  <= 1'b0;
      mole_tick_q <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      sec_cnt_q   <= sec_cnt_d;
      mole_cnt_q  <= mole_cnt_d;
      hits_q      <= hits_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      level_q     <= level_d;
      sec_tick_q  <= sec_tick_d;
      mole_tick_q <= mole_tick_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.time_left = time_left_q;
  assign bus.score     = score_q;
  assign bus.level     = level_q;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.mole_tick = mole_tick_q;
  assign bus.playing   = playing_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler with tick scoreboards.
module tb_game_round_scheduler;

  typedef struct {
    int cyc;
    int tl;
    int st;
  } sec_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  sec_exp_t exp_sec[$];
  int       exp_mole[$];

  game_round_scheduler_if bus ();

  game_round_scheduler #(
    .SEC_CYCLES      (10),
    .COUNTDOWN_SECS  (3),
    .GAME_SECS       (4),
    .HITS_PER_LEVEL  (2),
    .MAX_LEVEL       (3),
    .BASE_MOLE_CYCLES(8),
    .MOLE_STEP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Edge index: value after edge n is observed while cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_sec(input int c, input int tl, input int st);
    sec_exp_t e;
    e.cyc = c;
    e.tl  = tl;
    e.st  = st;
    exp_sec.push_back(e);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive for one cycle; returns with cyc equal to the sampling edge.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic pulse_hit();
    bus.hit = 1'b1;
    @(posedge clk);
    #1;
    bus.hit = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, int'(bus.state), 0);
    chk({tag, "_time_left"}, int'(bus.time_left), 0);
    chk({tag, "_score"}, int'(bus.score), 0);
    chk({tag, "_level"}, int'(bus.level), 0);
    chk({tag, "_sec_tick"}, int'(bus.sec_tick), 0);
    chk({tag, "_mole_tick"}, int'(bus.mole_tick), 0);
    chk({tag, "_playing"}, int'(bus.playing), 0);
    chk({tag, "_game_over"}, int'(bus.game_over), 0);
  endtask

  // Tick monitor: every observed tick pops the next expected one.
  always @(negedge clk) begin
    sec_exp_t e;
    int       m;
    if (!rst) begin
      if (bus.sec_tick) begin
        if (exp_sec.size() > 0) begin
          e = exp_sec.pop_front();
        end else begin
          e.cyc = -1;
          e.tl  = -1;
          e.st  = -1;
        end
        chk("sec_tick_cycle", cyc, e.cyc);
        chk("sec_tick_time_left", int'(bus.time_left), e.tl);
        chk("sec_tick_state", int'(bus.state), e.st);
      end
      if (bus.mole_tick) begin
        m = (exp_mole.size() > 0) ? exp_mole.pop_front() : -1;
        chk("mole_tick_cycle", cyc, m);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Round 1: no hits.
    step_to(5);
    push_sec(16, 2, 1); push_sec(26, 1, 1); push_sec(36, 4, 2);
    push_sec(46, 3, 2); push_sec(56, 2, 2); push_sec(66, 1, 2); push_sec(76, 0, 3);
    exp_mole = '{44, 52, 60, 68, 76};
    pulse_start();
    chk("r1_start_state", int'(bus.state), 1);
    chk("r1_start_time_left", int'(bus.time_left), 3);
    chk("r1_cd_playing", int'(bus.playing), 0);
    step_to(40);
    chk("r1_play_state", int'(bus.state), 2);
    chk("r1_play_playing", int'(bus.playing), 1);
    chk("r1_play_game_over", int'(bus.game_over), 0);
    step_to(80);
    chk("r1_end_state", int'(bus.state), 3);
    chk("r1_end_time_left", int'(bus.time_left), 0);
    chk("r1_end_score", int'(bus.score), 0);
    chk("r1_end_level", int'(bus.level), 0);
    chk("r1_end_game_over", int'(bus.game_over), 1);
    chk("r1_end_playing", int'(bus.playing), 0);
    chk("r1_sec_left", exp_sec.size(), 0);
    chk("r1_mole_left", exp_mole.size(), 0);

    // Round 2: restart from GAMEOVER, hits drive level-ups (play entry at 111).
    push_sec(91, 2, 1); push_sec(101, 1, 1); push_sec(111, 4, 2);
    push_sec(121, 3, 2); push_sec(131, 2, 2); push_sec(141, 1, 2); push_sec(151, 0, 3);
    exp_mole = '{119, 126, 132, 136, 140, 142, 144, 146, 148, 150};
    pulse_start();
    chk("r2_start_state", int'(bus.state), 1);
    chk("r2_start_time_left", int'(bus.time_left), 3);
    step_to(113); pulse_hit();
    chk("r2_hit1_score", int'(bus.score), 1);
    chk("r2_hit1_level", int'(bus.level), 0);
    // Mole counter is 6 here and level 1 makes P=6: tick must follow at 126.
    step_to(124); pulse_hit();
    chk("r2_hit2_level", int'(bus.level), 1);
    step_to(127); pulse_hit();
    step_to(133); pulse_hit();
    chk("r2_hit4_score", int'(bus.score), 4);
    chk("r2_hit4_level", int'(bus.level), 2);
    step_to(136); pulse_hit();
    step_to(140); pulse_hit();
    chk("r2_hit6_score", int'(bus.score), 6);
    chk("r2_hit6_level", int'(bus.level), 3);
    // Hit lands on the final second tick.
    step_to(150); pulse_hit();
    chk("r2_final_score", int'(bus.score), 7);
    chk("r2_final_level_sat", int'(bus.level), 3);
    chk("r2_final_state", int'(bus.state), 3);
    chk("r2_final_time_left", int'(bus.time_left), 0);
    chk("r2_final_game_over", int'(bus.game_over), 1);
    step_to(158);
    chk("r2_hold_score", int'(bus.score), 7);
    chk("r2_sec_left", exp_sec.size(), 0);
    chk("r2_mole_left", exp_mole.size(), 0);

    // Round 3: ignored pulses, then reset mid-PLAY (play entry at 191).
    step_to(160);
    push_sec(171, 2, 1); push_sec(181, 1, 1); push_sec(191, 4, 2);
    push_sec(201, 3, 2); push_sec(211, 2, 2);
    exp_mole = '{197, 203, 209};
    pulse_start();
    chk("r3_start_state", int'(bus.state), 1);
    chk("r3_start_score", int'(bus.score), 0);
    chk("r3_start_level", int'(bus.level), 0);
    chk("r3_start_time_left", int'(bus.time_left), 3);
    step_to(165); pulse_start(); pulse_hit();
    chk("r3_cd_ignore_state", int'(bus.state), 1);
    chk("r3_cd_ignore_score", int'(bus.score), 0);
    chk("r3_cd_ignore_time_left", int'(bus.time_left), 3);
    step_to(191); pulse_hit(); pulse_hit(); pulse_hit();
    chk("r3_play_score", int'(bus.score), 3);
    chk("r3_play_level", int'(bus.level), 1);
    pulse_start();
    chk("r3_play_ignore_start", int'(bus.state), 2);
    step_to(211);
    chk("r3_pre_rst_time_left", int'(bus.time_left), 2);
    chk("r3_pre_rst_score", int'(bus.score), 3);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("held_rst");
    rst = 1'b0;
    pulse_hit();
    chk("idle_hit_state", int'(bus.state), 0);
    chk("idle_hit_score", int'(bus.score), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("idle_state", int'(bus.state), 0);
    chk("end_sec_left", exp_sec.size(), 0);
    chk("end_mole_left", exp_mole.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
